// File: rtl/sample_sink.sv
// ---------------------------------------------------------------------------
// sample_sink
//
// Receiving end of the tagged sample stream. Samples (payload + 16-bit tag)
// are accepted through a valid/ready handshake into a DEPTH-entry FIFO and
// handed to a downstream reader through a registered read port. A sequence
// checker compares each accepted tag against the expected next tag and
// records discontinuities.
//
// Parameters:
//   WIDTH  payload width in bits
//   DEPTH  FIFO entries (power of two, >= 2)
//   CW     occupancy count width, derived as $clog2(DEPTH)+1
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   in_valid   producer offers a sample on in_data/in_tag
//   in_data    sample payload
//   in_tag     sample sequence tag
//   in_ready   sink can accept a sample this cycle
//   rd_en      reader requests one sample
//   rd_valid   rd_data/rd_tag valid (one-cycle pulse)
//   rd_data    popped payload (holds when rd_valid is low)
//   rd_tag     popped tag (holds when rd_valid is low)
//   count      current FIFO occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   seq_err    sticky tag-discontinuity flag
//   underflow  sticky read-while-empty flag
//   err_cnt    saturating count of tag discontinuities
//   clr_err    synchronous clear of seq_err, underflow and err_cnt
// ---------------------------------------------------------------------------
module sample_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [15:0]      in_tag,
    output logic             in_ready,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [15:0]      rd_tag,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             seq_err,
    output logic             underflow,
    output logic [15:0]      err_cnt,
    input  logic             clr_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [15:0]      tag_mem  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   exp_tag;

    logic wr_accept;
    logic pop;
    logic underflow_event;
    logic tag_bad;

    // Status flags come only from the registered occupancy, so in_ready has
    // no combinational path from in_valid or rd_en. A full FIFO refuses a
    // write even if a read happens in the same cycle.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    // An empty FIFO never bypasses a same-cycle write to the read port; the
    // read is reported as underflow instead.
    assign wr_accept       = in_valid && !full;
    assign pop             = rd_en && !empty;
    assign underflow_event = rd_en && empty;
    assign tag_bad         = wr_accept && (in_tag != exp_tag);

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            data_mem[wr_ptr] <= in_data;
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count only moves when exactly one
    // of write/pop happens.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !wr_accept) begin
                count <= count - CW'(1);
            end
        end
    end

    // Registered read port: head entry appears the cycle after the pop, and
    // the data/tag registers hold their value between pops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_tag   <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= data_mem[rd_ptr];
                rd_tag  <= tag_mem[rd_ptr];
            end
        end
    end

    // Sequence checker: every accepted write resyncs the expected tag to the
    // received tag plus one, so a single jump is counted once. Refused writes
    // are ignored.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exp_tag <= '0;
        end else if (wr_accept) begin
            exp_tag <= in_tag + 16'd1;
        end
    end

    // Error bookkeeping: an error event in the same cycle as clr_err wins, so
    // the flag ends set and the counter restarts at one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            seq_err   <= 1'b0;
            underflow <= 1'b0;
            err_cnt   <= '0;
        end else if (clr_err) begin
            seq_err   <= tag_bad;
            underflow <= underflow_event;
            err_cnt   <= tag_bad ? 16'd1 : 16'd0;
        end else begin
            if (tag_bad) begin
                seq_err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (underflow_event) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_sink.sv
// ---------------------------------------------------------------------------
// tb_sample_sink
//
// Self-checking bench for sample_sink. A queue-based model of the FIFO,
// read port and sequence checker predicts every output after each clock;
// directed steps cover fill/drain, wrap, sequence errors, underflow/clear
// and asynchronous reset, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_sample_sink;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [15:0]      in_tag;
    logic             in_ready;
    logic             rd_en;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [15:0]      rd_tag;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             seq_err;
    logic             underflow;
    logic [15:0]      err_cnt;
    logic             clr_err;

    sample_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .seq_err   (seq_err),
        .underflow (underflow),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [15+WIDTH:0] m_q[$];
    logic [15:0]       m_exp_tag;
    logic              m_rd_valid;
    logic [WIDTH-1:0]  m_rd_data;
    logic [15:0]       m_rd_tag;
    logic              m_seq_err;
    logic              m_underflow;
    logic [15:0]       m_err_cnt;
    int                max_count;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic checkAll(input string step);
        int n;
        n = m_q.size();
        checkOutput({step, ":in_ready"},  32'(in_ready),  32'(n < DEPTH));
        checkOutput({step, ":rd_valid"},  32'(rd_valid),  32'(m_rd_valid));
        checkOutput({step, ":rd_data"},   32'(rd_data),   32'(m_rd_data));
        checkOutput({step, ":rd_tag"},    32'(rd_tag),    32'(m_rd_tag));
        checkOutput({step, ":count"},     32'(count),     32'(n));
        checkOutput({step, ":full"},      32'(full),      32'(n == DEPTH));
        checkOutput({step, ":empty"},     32'(empty),     32'(n == 0));
        checkOutput({step, ":seq_err"},   32'(seq_err),   32'(m_seq_err));
        checkOutput({step, ":underflow"}, 32'(underflow), 32'(m_underflow));
        checkOutput({step, ":err_cnt"},   32'(err_cnt),   32'(m_err_cnt));
    endtask

    task automatic modelReset();
        m_q.delete();
        m_exp_tag   = 16'd0;
        m_rd_valid  = 1'b0;
        m_rd_data   = '0;
        m_rd_tag    = 16'd0;
        m_seq_err   = 1'b0;
        m_underflow = 1'b0;
        m_err_cnt   = 16'd0;
    endtask

    // Drive one cycle of inputs, advance one clock, update the model from the
    // behavioural rules and compare every output.
    task automatic applyStimulus(input string step, input logic v, input logic [WIDTH-1:0] d,
                                 input logic [15:0] t, input logic r, input logic c);
        logic acc, pop, uf, bad;
        logic [15+WIDTH:0] head;
        in_valid = v;
        in_data  = d;
        in_tag   = t;
        rd_en    = r;
        clr_err  = c;
        acc = v && (m_q.size() < DEPTH);
        pop = r && (m_q.size() > 0);
        uf  = r && (m_q.size() == 0);
        bad = acc && (t != m_exp_tag);
        @(posedge CLK);
        #1;
        if (pop) begin
            head      = m_q.pop_front();
            m_rd_data = head[WIDTH-1:0];
            m_rd_tag  = head[15+WIDTH:WIDTH];
        end
        m_rd_valid = pop;
        if (acc) begin
            m_q.push_back({t, d});
            m_exp_tag = t + 16'd1;
        end
        if (c) begin
            m_seq_err   = bad;
            m_underflow = uf;
            m_err_cnt   = bad ? 16'd1 : 16'd0;
        end else begin
            if (bad) begin
                m_seq_err = 1'b1;
                if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
            end
            if (uf) m_underflow = 1'b1;
        end
        if (m_q.size() > max_count) max_count = m_q.size();
        checkAll(step);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, '0, 16'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must change
    // without waiting for a clock.
    task automatic asyncReset(input string step);
        RST = 1'b0;
        #2;
        modelReset();
        checkAll(step);
        RST = 1'b1;
    endtask

    initial begin
        logic [15:0] tag;
        logic        v, r, c;
        RST      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = 16'd0;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        max_count = 0;
        modelReset();

        // Reset / idle
        repeat (2) @(posedge CLK);
        #1;
        checkAll("reset_held");
        RST = 1'b1;
        idle(1);

        // Fill to full, then a refused fifth write
        for (int i = 0; i < 4; i++)
            applyStimulus("fill", 1'b1, WIDTH'(8'hA0 + i), 16'(i), 1'b0, 1'b0);
        applyStimulus("refused_write", 1'b1, 8'hEE, 16'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus("drain", 1'b0, '0, 16'd0, 1'b1, 1'b0);
        idle(1);

        // Stream 20 samples with a read every cycle after the first write
        asyncReset("reset_before_stream");
        max_count = 0;
        applyStimulus("stream_first", 1'b1, 8'h10, 16'd0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++)
            applyStimulus("stream", 1'b1, WIDTH'(8'h10 + i), 16'(i), 1'b1, 1'b0);
        applyStimulus("stream_last", 1'b0, '0, 16'd0, 1'b1, 1'b0);
        checkOutput("stream_max_count", 32'(max_count <= 1), 32'd1);

        // Sequence errors: 0,1,5,6 then FFFF,0000
        asyncReset("reset_before_seq");
        applyStimulus("seq_t0", 1'b1, 8'h01, 16'd0, 1'b1, 1'b0);
        applyStimulus("seq_t1", 1'b1, 8'h02, 16'd1, 1'b1, 1'b0);
        applyStimulus("seq_t5", 1'b1, 8'h03, 16'd5, 1'b1, 1'b0);
        applyStimulus("seq_t6", 1'b1, 8'h04, 16'd6, 1'b1, 1'b0);
        applyStimulus("seq_tFFFF", 1'b1, 8'h05, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus("seq_t0000", 1'b1, 8'h06, 16'h0000, 1'b1, 1'b0);
        checkOutput("seq_err_cnt_two", 32'(err_cnt), 32'd2);
        applyStimulus("seq_drain", 1'b0, '0, 16'd0, 1'b1, 1'b0);

        // Underflow, then clr_err together with a bad tag
        applyStimulus("underflow", 1'b0, '0, 16'd0, 1'b1, 1'b0);
        applyStimulus("clr_with_bad", 1'b1, 8'h77, 16'h1234, 1'b0, 1'b1);
        checkOutput("clr_bad_err_cnt", 32'(err_cnt), 32'd1);
        applyStimulus("clr_plain", 1'b0, '0, 16'd0, 1'b0, 1'b1);

        // Async reset with three samples buffered
        applyStimulus("pre_reset_w1", 1'b1, 8'h31, 16'h1235, 1'b0, 1'b0);
        applyStimulus("pre_reset_w2", 1'b1, 8'h32, 16'h1236, 1'b1, 1'b0);
        applyStimulus("pre_reset_w3", 1'b1, 8'h33, 16'h1237, 1'b0, 1'b0);
        asyncReset("async_reset_mid");
        applyStimulus("post_reset_t0", 1'b1, 8'h40, 16'd0, 1'b0, 1'b0);
        applyStimulus("post_reset_read", 1'b0, '0, 16'd0, 1'b1, 1'b0);
        idle(1);

        // Randomized traffic: a fill-biased phase then a drain-biased phase
        tag = m_exp_tag;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            r = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            tag = ($urandom_range(0, 9) == 0) ? 16'($urandom) : m_exp_tag;
            applyStimulus("random", v, WIDTH'($urandom), tag, r, c);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sample_sink.md
# sample_sink

Receiving end of the tagged sample stream. Each sample carries a WIDTH-bit payload and a 16-bit sequence tag. The block accepts samples through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It checks that tags arrive in sequence and hands samples out to a downstream reader through a registered read port. It sits between the sample producer and the consumer logic and absorbs short rate mismatches.

## Interface
Parameters:
- WIDTH, 8, sample payload width in bits (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, occupancy count width (derived, not overridden)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a sample on in_data/in_tag
- in_data  in  WIDTH  sample payload
- in_tag  in  16  sample sequence tag
- in_ready  out  1  sink can accept a sample this cycle
- rd_en  in  1  reader requests one sample
- rd_valid  out  1  rd_data/rd_tag valid (one-cycle pulse)
- rd_data  out  WIDTH  popped payload
- rd_tag  out  16  popped tag
- count  out  CW  current FIFO occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- seq_err  out  1  sticky: tag discontinuity seen
- underflow  out  1  sticky: rd_en while empty
- err_cnt  out  16  number of tag discontinuities, saturates at 16'hFFFF
- clr_err  in  1  synchronous clear of seq_err, underflow and err_cnt

## Operation
- **Write.** A sample is accepted when in_valid && in_ready.
  - in_ready = !full, combinational from registered state only.
  - No dependency on rd_en in the same cycle: a full FIFO refuses the write even if a read occurs that cycle.
- **Read.**
  - A pop occurs when rd_en && !empty.
  - The head entry is registered onto rd_data/rd_tag, and rd_valid = 1 on the next cycle.
  - rd_data/rd_tag hold their last value when rd_valid = 0.
- **Underflow.** rd_en && empty causes no pop and sets underflow.
- **Pointers.**
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count increments on write-only, decrements on pop-only, and is unchanged when both occur in the same cycle.
- **Simultaneous write and read.**
  - Non-empty, non-full FIFO: both happen.
  - Empty FIFO: the write is accepted and the read is treated as underflow. The new sample is not bypassed to the read port.
- **Sequence checker.**
  - Register exp_tag, reset value 0.
  - On each accepted write with in_tag != exp_tag: set seq_err and increment err_cnt (saturating).
  - On every accepted write, exp_tag <= in_tag + 1 mod 2^16, so the checker resyncs to the received tag. 16'hFFFF → 16'h0000 is in sequence.
  - The checker is not evaluated on refused writes.
- **clr_err.**
  - Clears seq_err, underflow and err_cnt.
  - An error event in the same cycle wins: the flag ends at 1 and err_cnt ends at 1.
  - clr_err does not affect exp_tag or FIFO contents.

## Timing
- **Reset values (async assert, RST low):**
  - in_ready = 1, rd_valid = 0, rd_data = 0, rd_tag = 0, count = 0, full = 0, empty = 1.
  - seq_err = 0, underflow = 0, err_cnt = 0.
  - Pointers and exp_tag = 0.
  - FIFO storage need not be reset.
- **Reset mid-operation:** all buffered samples are discarded and outputs take reset values immediately. The first sample after release is checked against tag 0.
- **Latency:**
  - A write at edge N is visible in count/empty after edge N.
  - A pop issued in cycle N gives rd_valid high in cycle N+1.
  - Minimum write-to-read-data latency is 2 cycles.
- **Throughput:** one write and one read per cycle are sustained indefinitely when 0 < count < DEPTH.
- **Status timing:** full, empty and count are registered-state derived, with no combinational path from in_valid or rd_en to in_ready.

## Test plan
- **Reset/idle:** hold RST low, then release → all outputs at reset values; in_ready = 1, empty = 1, count = 0.
- **Fill/drain:** write tags 0,1,2,3 with data 8'hA0..8'hA3 at DEPTH=4.
  - After the 4th write: full = 1, in_ready = 0, and a 5th in_valid is refused with count staying 4.
  - Pop 4 times → rd_data A0..A3 and rd_tag 0..3 in order, each one cycle after rd_en; then empty = 1.
- **Wrap and concurrency:** stream 20 samples while issuing rd_en every cycle after the first write → the output order matches the input order across pointer wrap, and count never exceeds 1.
- **Sequence error:** send tags 0,1,5,6 → seq_err = 1 and err_cnt = 1 after tag 5, with no further increment for tag 6.
  - Then send tag 16'hFFFF followed by 16'h0000 → err_cnt = 2, since the wrap itself is in sequence.
- **Underflow and clear:**
  - rd_en on an empty FIFO → underflow = 1, rd_valid stays 0.
  - clr_err in the same cycle as a bad tag → seq_err = 1, err_cnt = 1, underflow = 0.
- **Async reset mid-stream:** assert RST with count = 3 → count = 0, rd_valid = 0, flags cleared without waiting for a clock edge. The next sample with tag 0 raises no error.
